// File: rtl/fp32_mult_seq.sv
// rtl/fp32_mult_seq.sv - sequential shift-add IEEE-754 single multiplier, enable/done handshake
// Optional build macro: FP32_MULT_ROUND_NEAREST_EN (round-to-nearest-even; default truncates)
module fp32_mult_seq #(
    parameter int ITER_BITS = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [31:0] dataa,
    input  logic [31:0] datab,
    output logic [31:0] result,
    output logic        done
);

    localparam int N_ITER = 24 / ITER_BITS;
    localparam int CW     = 5;

    generate
        if (!(ITER_BITS == 1 || ITER_BITS == 2 || ITER_BITS == 4 || ITER_BITS == 8)) begin : g_bad_iter
            $error("fp32_mult_seq: ITER_BITS must be 1, 2, 4 or 8");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_MULT,
        S_NORM,
        S_ROUND,
        S_DONE
    } state_t;

    state_t             state;
    logic [31:0]        a_r;
    logic [31:0]        b_r;
    logic               sign_r;
    logic signed [9:0]  exp_r;
    logic [47:0]        ma_sh;
    logic [23:0]        mb_r;
    logic [47:0]        acc;
    logic [CW-1:0]      cnt;
    logic [31:0]        res_r;

    logic [7:0]  ea, eb;
    logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, sgn;
    logic [47:0] pp;
    logic [24:0] mant_rnd;
    logic signed [9:0] exp_rnd;
    logic [22:0] frac_fin;

    always_comb begin
        ea     = a_r[30:23];
        eb     = b_r[30:23];
        a_zero = (ea == 8'h00);
        b_zero = (eb == 8'h00);
        a_inf  = (ea == 8'hFF) && (a_r[22:0] == 23'd0);
        b_inf  = (eb == 8'hFF) && (b_r[22:0] == 23'd0);
        a_nan  = (ea == 8'hFF) && (a_r[22:0] != 23'd0);
        b_nan  = (eb == 8'hFF) && (b_r[22:0] != 23'd0);
        sgn    = a_r[31] ^ b_r[31];
    end

    // Partial product of the low ITER_BITS multiplier bits against the pre-shifted multiplicand
    always_comb begin
        pp = '0;
        for (int i = 0; i < ITER_BITS; i++) begin
            if (mb_r[i]) begin
                pp = pp + (ma_sh << i);
            end
        end
    end

    always_comb begin
`ifdef FP32_MULT_ROUND_NEAREST_EN
        mant_rnd = {1'b0, acc[46:23]}
                 + {24'd0, acc[22] & (acc[21] | (|acc[20:0]) | acc[23])};
`else
        mant_rnd = {1'b0, acc[46:23]};
`endif
        exp_rnd  = mant_rnd[24] ? (exp_r + 10'sd1) : exp_r;
        frac_fin = mant_rnd[24] ? mant_rnd[23:1] : mant_rnd[22:0];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= S_IDLE;
            done   <= 1'b0;
            result <= 32'h0000_0000;
            a_r    <= '0;
            b_r    <= '0;
            sign_r <= 1'b0;
            exp_r  <= '0;
            ma_sh  <= '0;
            mb_r   <= '0;
            acc    <= '0;
            cnt    <= '0;
            res_r  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (enable) begin
                        a_r   <= dataa;
                        b_r   <= datab;
                        state <= S_UNPACK;
                    end
                end
                S_UNPACK: begin
                    sign_r <= sgn;
                    if (!enable) begin
                        state <= S_IDLE;
                    end else if (a_nan || b_nan || ((a_inf || b_inf) && (a_zero || b_zero))) begin
                        res_r <= 32'h7FC0_0000;
                        state <= S_DONE;
                    end else if (a_inf || b_inf) begin
                        res_r <= {sgn, 8'hFF, 23'd0};
                        state <= S_DONE;
                    end else if (a_zero || b_zero) begin
                        res_r <= {sgn, 31'd0};
                        state <= S_DONE;
                    end else begin
                        ma_sh <= {24'd0, 1'b1, a_r[22:0]};
                        mb_r  <= {1'b1, b_r[22:0]};
                        exp_r <= $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
                        acc   <= '0;
                        cnt   <= '0;
                        state <= S_MULT;
                    end
                end
                S_MULT: begin
                    if (!enable) begin
                        state <= S_IDLE;
                    end else begin
                        acc   <= acc + pp;
                        ma_sh <= ma_sh << ITER_BITS;
                        mb_r  <= mb_r >> ITER_BITS;
                        cnt   <= cnt + 1'b1;
                        if (cnt == CW'(N_ITER - 1)) begin
                            state <= S_NORM;
                        end
                    end
                end
                S_NORM: begin
                    if (!enable) begin
                        state <= S_IDLE;
                    end else begin
                        // Keep the dropped bit alive in the sticky position
                        if (acc[47]) begin
                            acc   <= {1'b0, acc[47:2], acc[1] | acc[0]};
                            exp_r <= exp_r + 10'sd1;
                        end
                        state <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    if (!enable) begin
                        state <= S_IDLE;
                    end else begin
                        if (exp_rnd >= 10'sd255) begin
                            res_r <= {sign_r, 8'hFF, 23'd0};
                        end else if (exp_rnd <= 10'sd0) begin
                            res_r <= {sign_r, 31'd0};
                        end else begin
                            res_r <= {sign_r, exp_rnd[7:0], frac_fin};
                        end
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (!enable) begin
                        done  <= 1'b0;
                        state <= S_IDLE;
                    end else if (!done) begin
                        done   <= 1'b1;
                        result <= res_r;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
